seg_display_scheduler: RTL
==========================

Name: seg_display_scheduler

Overview:
Owns the 4-digit multiplexed 7-segment display and shares it between two normal sources (A, B) and one priority alert source. Scans digits 0-3 once per scan tick and time-slices the display between A and B by whole frames. An alert preempts immediately. Output nibble feeds the existing hex/BCD-to-segment decoder; AN drives the anodes directly.

Parameters:
DWELL_FRAMES, 250, complete 4-digit frames an A/B owner holds the display before rotation; legal range 1..65535.
CNT_W, 16, width of the dwell frame counter; must hold DWELL_FRAMES-1.

Ports:
clk_en  in  1  scan tick clock; one digit advance per rising edge (clock clk_en)
clr  in  1  reset, asynchronous, active-high
req_a  in  1  source A wants display (level)
data_a  in  16  A digits; digit n = data_a[4n+3:4n]
req_b  in  1  source B wants display (level)
data_b  in  16  B digits, same packing
alert  in  1  priority request (level)
alert_data  in  16  alert digits, same packing
AN  out  4  anodes, active-low, one-hot-low or 1111
S  out  2  index of the digit currently shown
digit  out  4  nibble for the currently shown digit
owner  out  2  00 none, 01 A, 10 B, 11 alert
frame_done  out  1  high while S==3 and owner!=00

Behaviour:
- Reset (async): AN=1111, S=0, digit=0, owner=00, frame_done=0, dwell counter=0, frame buffer=0, last_owner=A.
- All outputs are registered and mutually consistent every cycle: AN=~(1<<S), and digit=buffer nibble S. There is no one-cycle lag between S and AN.
- States: IDLE, SHOW_A, SHOW_B, SHOW_ALERT; owner encodes the state.
- IDLE: AN=1111, S=0. On an edge, the first true of the following is chosen: alert -> ALERT, req_a -> A, req_b -> B. That same edge starts a frame.
- Frame start (any edge entering digit 0 with a new or continuing owner):
  - Latch the owner's 16-bit data into the frame buffer.
  - Output S=0, AN=1110, digit=data[3:0] from the live input.
  - Data changes after this have no effect until the next frame start (no tearing).
- Mid-frame edges: S<=S+1, AN<=~(1<<(S+1)), digit<=buffer nibble S+1.
- Frame boundary is the edge at which S==3:
  - In SHOW_A/SHOW_B, evaluate in this order:
    - alert -> ALERT, with last_owner=current.
    - Own req low, or dwell==DWELL_FRAMES-1: go to the other source if it requests. Otherwise stay if own req is high (dwell reset to 0). Otherwise go IDLE.
    - Else stay, dwell+1.
  - In SHOW_ALERT:
    - alert high -> stay.
    - Otherwise go to last_owner if it requests, else the other source if it requests, else IDLE.
  - Any owner change clears dwell to 0.
  - The new frame starts on the same edge; entering IDLE outputs AN=1111, S=0, digit=0.
- Alert preemption: alert sampled high on any edge while in SHOW_A/SHOW_B, not only at a frame boundary.
  - That edge enters SHOW_ALERT and starts a frame (S=0, digit=alert_data[3:0]).
  - Record last_owner; clear dwell.
- Latency: 1 edge from request sampled to first digit shown. A/B rotation occurs only at frame boundaries.
- Simultaneous req_a and req_b from IDLE: A wins. Rotation is round-robin thereafter.
- A source dropping req mid-frame: the frame completes with buffered data, then the boundary rule applies.
- DWELL_FRAMES=1: rotate every frame while both request.
- S wraps 3->0 only via the frame-start rule. No X, no undefined state; illegal state encoding recovers to IDLE.
- clr mid-frame: outputs go to reset values immediately. After release, IDLE rules apply on the next edge.

Test Plan:
- clr asserted while S=2, owner=01 -> same cycle AN=1111, S=0, digit=0, owner=00. Release with req_a=1 -> next edge AN=1110.
- DWELL_FRAMES=2, req_a only, data_a=16'h1234 -> AN 1110,1101,1011,0111 repeating; digit 4,3,2,1; owner stays 01; frame_done high every 4th edge.
- DWELL_FRAMES=2, req_a=req_b=1, data_a=16'h1111, data_b=16'h2222 -> 8 edges owner=01, 8 edges owner=10, alternating. data_a changed to 16'h9999 at S=1 -> current frame still shows 1s, next A frame shows 9s.
- Owner=01 at S=2, alert=1 with alert_data=16'hEEEE -> next edge owner=11, S=0, AN=1110, digit=E. alert dropped at S=1 -> frame completes to S=3, then owner=01, dwell restarted.
- req_a and req_b drop at S=1 -> S continues to 3 with old digits, next edge owner=00, AN=1111.
- Owner=01, req_b=1, req_a drops mid-frame -> frame completes, next edge owner=10, digit=data_b[3:0].

Source files
------------

// File: rtl/seg_display_scheduler_if.sv
// Request/data inputs and display outputs of the 7-segment scheduler.
// The slave modport is the scheduler. The master modport is the driving side.
interface seg_display_scheduler_if;
  logic        req_a;
  logic [15:0] data_a;
  logic        req_b;
  logic [15:0] data_b;
  logic        alert;
  logic [15:0] alert_data;
  logic [3:0]  AN;
  logic [1:0]  S;
  logic [3:0]  digit;
  logic [1:0]  owner;
  logic        frame_done;

  modport master (
    output req_a, data_a, req_b, data_b, alert, alert_data,
    input  AN, S, digit, owner, frame_done
  );

  modport slave (
    input  req_a, data_a, req_b, data_b, alert, alert_data,
    output AN, S, digit, owner, frame_done
  );
endinterface

// File: rtl/seg_display_scheduler.sv
// Scans a 4-digit multiplexed display and time-slices it between sources A and B by whole frames.
// A priority alert source can take the display on any scan tick.
module seg_display_scheduler #(
  parameter int unsigned DWELL_FRAMES = 250,
  parameter int unsigned CNT_W        = 16
) (
  input logic                    clk_en,
  input logic                    clr,
  seg_display_scheduler_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle      = 2'b00,
    StShowA     = 2'b01,
    StShowB     = 2'b10,
    StShowAlert = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] DwellLast = CNT_W'(DWELL_FRAMES - 1);

  state_e           state_q, state_d, oth_st;
  logic [1:0]       s_q, s_d;
  logic [3:0]       an_q, an_d;
  logic [3:0]       digit_q, digit_d;
  logic             frame_done_q, frame_done_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [15:0]      buf_q, buf_d;
  logic             last_b_q, last_b_d;  // source to return to after an alert: 0 = A, 1 = B
  logic             start, own_req, oth_req;
  logic [15:0]      sel_data;

  function automatic logic [3:0] nibble(input logic [15:0] d, input logic [1:0] idx);
    logic [3:0] n;
    case (idx)
      2'd0:    n = d[3:0];
      2'd1:    n = d[7:4];
      2'd2:    n = d[11:8];
      default: n = d[15:12];
    endcase
    return n;
  endfunction

  always_comb begin
    state_d      = state_q;
    dwell_d      = dwell_q;
    last_b_d     = last_b_q;
    buf_d        = buf_q;
    start        = 1'b0;
    own_req      = 1'b0;
    oth_req      = 1'b0;
    oth_st       = StIdle;
    sel_data     = 16'h0000;
    s_d          = 2'd0;
    an_d         = 4'hF;
    digit_d      = 4'h0;
    frame_done_d = 1'b0;

    case (state_q)
      StIdle: begin
        start   = 1'b1;
        dwell_d = '0;
        if (bus.alert)      state_d = StShowAlert;
        else if (bus.req_a) state_d = StShowA;
        else if (bus.req_b) state_d = StShowB;
        else                start   = 1'b0;
      end
      StShowA, StShowB: begin
        own_req = (state_q == StShowA) ? bus.req_a : bus.req_b;
        oth_req = (state_q == StShowA) ? bus.req_b : bus.req_a;
        oth_st  = (state_q == StShowA) ? StShowB : StShowA;
        if (bus.alert) begin
          // Preemption is allowed mid-frame, unlike A/B rotation.
          state_d  = StShowAlert;
          last_b_d = (state_q == StShowB);
          dwell_d  = '0;
          start    = 1'b1;
        end else if (s_q == 2'd3) begin
          start = 1'b1;
          if (!own_req || dwell_q == DwellLast) begin
            dwell_d = '0;
            if (oth_req)       state_d = oth_st;
            else if (!own_req) state_d = StIdle;
          end else begin
            dwell_d = dwell_q + CNT_W'(1);
          end
        end
      end
      StShowAlert: begin
        if (s_q == 2'd3) begin
          start   = 1'b1;
          dwell_d = '0;
          if (!bus.alert) begin
            if (last_b_q ? bus.req_b : bus.req_a)      state_d = last_b_q ? StShowB : StShowA;
            else if (last_b_q ? bus.req_a : bus.req_b) state_d = last_b_q ? StShowA : StShowB;
            else                                       state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    case (state_d)
      StShowA:     sel_data = bus.data_a;
      StShowB:     sel_data = bus.data_b;
      StShowAlert: sel_data = bus.alert_data;
      default:     sel_data = 16'h0000;
    endcase

    // Outputs are computed from the next state so AN, S and digit never lag each other.
    if (state_d != StIdle) begin
      if (start) begin
        buf_d   = sel_data;
        s_d     = 2'd0;
        digit_d = sel_data[3:0];
      end else begin
        s_d     = s_q + 2'd1;
        digit_d = nibble(buf_q, s_d);
      end
      an_d         = ~(4'b0001 << s_d);
      frame_done_d = (s_d == 2'd3);
    end
  end

  always_ff @(posedge clk_en or posedge clr) begin
    if (clr) begin
      state_q      <= StIdle;
      s_q          <= 2'd0;
      an_q         <= 4'hF;
      digit_q      <= 4'h0;
      frame_done_q <= 1'b0;
      dwell_q      <= '0;
      buf_q        <= 16'h0000;
      last_b_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      s_q          <= s_d;
      an_q         <= an_d;
      digit_q      <= digit_d;
      frame_done_q <= frame_done_d;
      dwell_q      <= dwell_d;
      buf_q        <= buf_d;
      last_b_q     <= last_b_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.S          = s_q;
  assign bus.digit      = digit_q;
  assign bus.owner      = state_q;
  assign bus.frame_done = frame_done_q;

endmodule
